// File: rtl/i2c_target_rsp.sv
//------------------------------------------------------------------------------
// i2c_target_rsp
//
// I2C target (slave) responder with a fixed 7-bit address. The bus lines are
// oversampled on the system clock. START, STOP, address and data are decoded
// on the synchronized lines. The block ACKs its own address and every write
// byte.
//
// Write bytes are handed to local logic with a one-cycle strobe. Read bytes
// are fetched from local logic through a request/valid handshake, and SCL is
// held low (clock stretching) while a read byte is pending.
//
// Ports
//   clk_i       system clock (at least 16x the SCL rate)
//   rst_i       synchronous reset, active low
//   scl_i/sda_i bus lines as seen on the pins
//   scl_o/sda_o open-drain drivers: 0 pulls the line low, 1 releases it
//   start_o     one-cycle pulse on START or repeated START
//   stop_o      one-cycle pulse on STOP
//   rw_o        R/W bit of the last matched address (1 = read)
//   wr_data_o   last received write byte
//   wr_valid_o  one-cycle pulse when wr_data_o is updated
//   rd_req_o    level: a read byte is needed
//   rd_data_i   read byte from local logic
//   rd_valid_i  rd_data_i valid; accepted when rd_req_o && rd_valid_i
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_target_rsp #(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      rw_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    output logic                      rd_req_o,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_RD_BYTE  = 3'd6;
    localparam logic [2:0] ST_RD_ACK   = 3'd7;

    // Bit counter values: a full byte, and a marker that the master ACKed a
    // read byte (the counter itself never wraps).
    localparam logic [3:0] BYTE_BITS = 4'(I2C_DATA_WIDTH);
    localparam logic [3:0] LAST_BIT  = 4'(I2C_DATA_WIDTH - 1);
    localparam logic [3:0] ACK_SEEN  = 4'(I2C_DATA_WIDTH + 1);

    logic                      scl_s1_r;
    logic                      scl_s2_r;
    logic                      scl_d_r;
    logic                      sda_s1_r;
    logic                      sda_s2_r;
    logic                      sda_d_r;

    logic [2:0]                state_r;
    logic [3:0]                bit_cnt_r;
    logic [I2C_DATA_WIDTH-1:0] shift_r;
    logic [I2C_DATA_WIDTH-1:0] tx_r;

    logic                      scl_rise_s;
    logic                      scl_fall_s;
    logic                      start_det_s;
    logic                      stop_det_s;
    logic                      addr_match_s;
    logic [I2C_DATA_WIDTH-1:0] shift_next_s;

    // Two-flop synchronizers plus one history stage for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            scl_d_r  <= 1'b1;
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
            sda_d_r  <= 1'b1;
        end else begin
            scl_s1_r <= scl_i;
            scl_s2_r <= scl_s1_r;
            scl_d_r  <= scl_s2_r;
            sda_s1_r <= sda_i;
            sda_s2_r <= sda_s1_r;
            sda_d_r  <= sda_s2_r;
        end
    end

    // Bus event decode on the synchronized lines
    always_comb begin
        scl_rise_s   = scl_s2_r & ~scl_d_r;
        scl_fall_s   = ~scl_s2_r & scl_d_r;
        // SDA moving while SCL is high is a bus condition, never data.
        start_det_s  = sda_d_r & ~sda_s2_r & scl_s2_r;
        stop_det_s   = ~sda_d_r & sda_s2_r & scl_s2_r;
        shift_next_s = {shift_r[I2C_DATA_WIDTH-2:0], sda_s2_r};
        addr_match_s = (shift_r[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR);
    end

    // Protocol state machine and registered bus/local outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            tx_r       <= '0;
            sda_o      <= 1'b1;
            scl_o      <= 1'b1;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            rw_o       <= 1'b0;
            wr_data_o  <= '0;
            wr_valid_o <= 1'b0;
            rd_req_o   <= 1'b0;
        end else begin
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid_o <= 1'b0;

            if (start_det_s) begin
                // START (or repeated START) aborts whatever was in progress.
                start_o   <= 1'b1;
                sda_o     <= 1'b1;
                scl_o     <= 1'b1;
                rd_req_o  <= 1'b0;
                bit_cnt_r <= 4'd0;
                shift_r   <= '0;
                state_r   <= ST_ADDR;
            end else if (stop_det_s) begin
                // STOP also withdraws a pending read request, consuming nothing.
                stop_o    <= 1'b1;
                sda_o     <= 1'b1;
                scl_o     <= 1'b1;
                rd_req_o  <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_o    <= 1'b1;
                        scl_o    <= 1'b1;
                        rd_req_o <= 1'b0;
                    end

                    ST_ADDR: begin
                        if (scl_rise_s && (bit_cnt_r < BYTE_BITS)) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            bit_cnt_r <= 4'd0;
                            if (addr_match_s) begin
                                sda_o   <= 1'b0;
                                rw_o    <= shift_r[0];
                                state_r <= ST_ADDR_ACK;
                            end else begin
                                // Not ours: leave SDA released (NACK) and
                                // sit out the rest of the transfer.
                                sda_o   <= 1'b1;
                                state_r <= ST_IDLE;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            sda_o     <= 1'b1;
                            bit_cnt_r <= 4'd0;
                            if (rw_o) begin
                                // SCL is low now; hold it there until the
                                // first read byte is supplied.
                                rd_req_o <= 1'b1;
                                scl_o    <= 1'b0;
                                state_r  <= ST_RD_WAIT;
                            end else begin
                                state_r  <= ST_WR_BYTE;
                            end
                        end
                    end

                    ST_WR_BYTE: begin
                        if (scl_rise_s && (bit_cnt_r < BYTE_BITS)) begin
                            shift_r   <= shift_next_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                wr_data_o  <= shift_next_s;
                                wr_valid_o <= 1'b1;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            sda_o     <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_WR_ACK;
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall_s) begin
                            sda_o     <= 1'b1;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_WR_BYTE;
                        end
                    end

                    ST_RD_WAIT: begin
                        if (rd_req_o && rd_valid_i) begin
                            // MSB goes out immediately; the rest shift out on
                            // the following SCL falls.
                            tx_r      <= {rd_data_i[I2C_DATA_WIDTH-2:0], 1'b1};
                            sda_o     <= rd_data_i[I2C_DATA_WIDTH-1];
                            rd_req_o  <= 1'b0;
                            scl_o     <= 1'b1;
                            bit_cnt_r <= 4'd1;
                            state_r   <= ST_RD_BYTE;
                        end else begin
                            scl_o <= 1'b0;
                        end
                    end

                    ST_RD_BYTE: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r < BYTE_BITS) begin
                                sda_o     <= tx_r[I2C_DATA_WIDTH-1];
                                tx_r      <= {tx_r[I2C_DATA_WIDTH-2:0], 1'b1};
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end else begin
                                // Last bit done: release SDA for the
                                // master's ACK/NACK.
                                sda_o     <= 1'b1;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_RD_ACK;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_s2_r) begin
                                bit_cnt_r <= ACK_SEEN;
                            end else begin
                                // NACK ends the read; wait for STOP or
                                // repeated START.
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_IDLE;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == ACK_SEEN)) begin
                            rd_req_o  <= 1'b1;
                            scl_o     <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_RD_WAIT;
                        end
                    end

                    default: begin
                        sda_o     <= 1'b1;
                        scl_o     <= 1'b1;
                        rd_req_o  <= 1'b0;
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_rsp.sv
//------------------------------------------------------------------------------
// tb_i2c_target_rsp
//
// Bench for i2c_target_rsp. Contents:
//   - a behavioural I2C master on a wired-AND bus
//   - a local-logic read responder with programmable latency
//   - a monitor that scores write strobes against a queue of expected bytes
//
// Read bytes are pushed to a scoreboard when the responder serves them. They
// are compared when the master finishes receiving them.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_target_rsp;

    localparam int Q = 50;  // quarter SCL period in ns (SCL = 20 clk periods)

    logic       clk;
    logic       rst_i;
    logic       scl_m;
    logic       sda_m;
    logic       scl_o;
    logic       sda_o;
    logic       start_o;
    logic       stop_o;
    logic       rw_o;
    logic [7:0] wr_data_o;
    logic       wr_valid_o;
    logic       rd_req_o;
    logic [7:0] rd_data_i;
    logic       rd_valid_i;

    wire scl_bus = scl_m & scl_o;
    wire sda_bus = sda_m & sda_o;

    i2c_target_rsp dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .rw_o       (rw_o),
        .wr_data_o  (wr_data_o),
        .wr_valid_o (wr_valid_o),
        .rd_req_o   (rd_req_o),
        .rd_data_i  (rd_data_i),
        .rd_valid_i (rd_valid_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] serve_q[$];

    int rd_delay    = 2;
    int start_cnt   = 0;
    int stop_cnt    = 0;
    int wr_cnt      = 0;
    int rdreq_cnt   = 0;
    int sda_low_cnt = 0;
    int max_scl_low = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       exp_ack;
    } tv_t;

    tv_t tv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_scl_high();
        int k;
        k = 0;
        while (!scl_bus && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!scl_bus) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout: SCL low after %0d cycles, required high", k);
        end
    endtask

    task automatic i2c_bit(input logic b, output logic r);
        sda_m = b;
        #(Q);
        scl_m = 1'b1;
        wait_scl_high();
        #(Q);
        r = sda_bus;
        #(Q);
        scl_m = 1'b0;
        #(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        #(Q);
        scl_m = 1'b1;
        wait_scl_high();
        #(Q);
        sda_m = 1'b0;
        #(Q);
        scl_m = 1'b0;
        #(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #(Q);
        scl_m = 1'b1;
        wait_scl_high();
        #(Q);
        sda_m = 1'b1;
        #(2*Q);
    endtask

    task automatic i2c_write(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], r);
        i2c_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic i2c_read(input logic do_ack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, r);
            b[i] = r;
        end
        i2c_bit(~do_ack, r);
    endtask

    task automatic sb_read(input string name, input logic [7:0] b);
        if (rd_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: read %0h with no byte served", name, b);
        end else begin
            check(name, {24'd0, b}, {24'd0, rd_exp_q.pop_front()});
        end
    endtask

    // Local logic: serve read bytes after rd_delay cycles of rd_req_o
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        rd_valid_i = 1'b0;
        rd_data_i  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_valid_i && !rd_req_o) begin
                rd_valid_i = 1'b0;
            end else if (rd_req_o && !rd_valid_i) begin
                if (wait_cnt < rd_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt  = 0;
                    rd_data_i = (serve_q.size() != 0) ? serve_q.pop_front() : 8'hEE;
                    rd_exp_q.push_back(rd_data_i);
                    rd_valid_i = 1'b1;
                end
            end
        end
    end

    // Output monitor and write scoreboard
    initial begin
        logic rd_req_prev;
        int   scl_run;
        rd_req_prev = 1'b0;
        scl_run     = 0;
        forever begin
            @(negedge clk);
            if (rst_i === 1'b1) begin
                if (start_o) start_cnt++;
                if (stop_o) stop_cnt++;
                if (!sda_o) sda_low_cnt++;
                if (!scl_o) begin
                    scl_run++;
                    if (scl_run > max_scl_low) max_scl_low = scl_run;
                end else begin
                    scl_run = 0;
                end
                if (rd_req_o && !rd_req_prev) rdreq_cnt++;
                rd_req_prev = rd_req_o;
                if (wr_valid_o) begin
                    wr_cnt++;
                    if (wr_exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: wr_data_o=%0h, no write expected", wr_data_o);
                    end else begin
                        check("wr_data", {24'd0, wr_data_o}, {24'd0, wr_exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] b;
        int         s0, p0, w0, r0, l0, nak;

        scl_m = 1'b1;
        sda_m = 1'b1;
        rst_i = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              {17'd0, sda_o, scl_o, start_o, stop_o, wr_valid_o, rd_req_o, rw_o, wr_data_o},
              {17'd0, 2'b11, 13'd0});
        rst_i = 1'b1;
        repeat (5) @(negedge clk);

        // Table: address match / mismatch with one write byte each
        tv[0] = '{8'h44, 8'h11, 1'b1};
        tv[1] = '{8'h46, 8'h22, 1'b0};
        tv[2] = '{8'h44, 8'hFF, 1'b1};
        tv[3] = '{8'h00, 8'h33, 1'b0};
        tv[4] = '{8'h44, 8'h00, 1'b1};
        tv[5] = '{8'hC4, 8'h55, 1'b0};
        s0 = start_cnt;
        p0 = stop_cnt;
        for (int t = 0; t < 6; t++) begin
            i2c_start();
            i2c_write(tv[t].addr, ack);
            check("tv_addr_ack", {31'd0, ack}, {31'd0, tv[t].exp_ack});
            if (tv[t].exp_ack) begin
                check("tv_rw", {31'd0, rw_o}, 32'd0);
                wr_exp_q.push_back(tv[t].data);
                i2c_write(tv[t].data, ack);
                check("tv_data_ack", {31'd0, ack}, 32'd1);
            end
            i2c_stop();
        end
        check("tv_start_cnt", start_cnt - s0, 32'd6);
        check("tv_stop_cnt", stop_cnt - p0, 32'd6);

        // Burst write of 0..31
        s0 = start_cnt; p0 = stop_cnt; w0 = wr_cnt; nak = 0;
        i2c_start();
        i2c_write(8'h44, ack);
        if (!ack) nak++;
        for (int i = 0; i < 32; i++) begin
            wr_exp_q.push_back(8'(i));
            i2c_write(8'(i), ack);
            if (!ack) nak++;
        end
        i2c_stop();
        check("t1_nak_count", nak, 32'd0);
        check("t1_wr_count", wr_cnt - w0, 32'd32);
        check("t1_start_cnt", start_cnt - s0, 32'd1);
        check("t1_stop_cnt", stop_cnt - p0, 32'd1);

        // Burst read of 100..131, last byte NACKed
        r0 = rdreq_cnt;
        for (int i = 0; i < 32; i++) serve_q.push_back(8'(100 + i));
        i2c_start();
        i2c_write(8'h45, ack);
        check("t2_addr_ack", {31'd0, ack}, 32'd1);
        check("t2_rw", {31'd0, rw_o}, 32'd1);
        for (int i = 0; i < 32; i++) begin
            i2c_read(i < 31, b);
            sb_read("t2_rd_data", b);
        end
        repeat (40) @(negedge clk);
        check("t2_rd_req_idle", {31'd0, rd_req_o}, 32'd0);
        i2c_stop();
        repeat (20) @(negedge clk);
        check("t2_rd_req_count", rdreq_cnt - r0, 32'd32);

        // Foreign address: no drive, no strobes
        w0 = wr_cnt; r0 = rdreq_cnt; l0 = sda_low_cnt;
        i2c_start();
        i2c_write(8'h46, ack);
        i2c_write(8'h12, ack);
        i2c_stop();
        check("t3_nak", {31'd0, ack}, 32'd0);
        check("t3_sda_low", sda_low_cnt - l0, 32'd0);
        check("t3_wr_count", wr_cnt - w0, 32'd0);
        check("t3_rdreq_count", rdreq_cnt - r0, 32'd0);

        // Write then repeated-START read, 32 iterations
        s0 = start_cnt; nak = 0;
        for (int i = 0; i < 32; i++) begin
            i2c_start();
            i2c_write(8'h44, ack);
            if (!ack) nak++;
            check("t4_rw_wr", {31'd0, rw_o}, 32'd0);
            wr_exp_q.push_back(8'(64 + i));
            i2c_write(8'(64 + i), ack);
            if (!ack) nak++;
            serve_q.push_back(8'(63 - i));
            i2c_start();
            i2c_write(8'h45, ack);
            if (!ack) nak++;
            check("t4_rw_rd", {31'd0, rw_o}, 32'd1);
            i2c_read(1'b0, b);
            sb_read("t4_rd_data", b);
            i2c_stop();
        end
        check("t4_nak_count", nak, 32'd0);
        check("t4_start_cnt", start_cnt - s0, 32'd64);

        // Long stretch while local logic is slow
        rd_delay = 500;
        serve_q.push_back(8'hA5);
        i2c_start();
        i2c_write(8'h45, ack);
        i2c_read(1'b0, b);
        i2c_stop();
        rd_delay = 2;
        sb_read("t5_rd_data", b);
        check("t5_rd_value", {24'd0, b}, 32'hA5);
        check("t5_stretch", {31'd0, max_scl_low >= 490}, 32'd1);

        // Reset in the middle of a write byte
        w0 = wr_cnt;
        i2c_start();
        i2c_write(8'h44, ack);
        i2c_bit(1'b1, ack);
        i2c_bit(1'b0, ack);
        i2c_bit(1'b1, ack);
        i2c_bit(1'b0, ack);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        check("t6_lines_released", {30'd0, sda_o, scl_o}, 32'd3);
        check("t6_wr_data_cleared", {24'd0, wr_data_o}, 32'd0);
        check("t6_rw_cleared", {31'd0, rw_o}, 32'd0);
        i2c_start();
        i2c_write(8'h44, ack);
        check("t6_addr_ack", {31'd0, ack}, 32'd1);
        wr_exp_q.push_back(8'h5A);
        i2c_write(8'h5A, ack);
        i2c_stop();
        check("t6_wr_count", wr_cnt - w0, 32'd1);
        check("t6_wr_data", {24'd0, wr_data_o}, 32'h5A);

        repeat (50) @(negedge clk);
        check("wr_queue_empty", wr_exp_q.size(), 32'd0);
        check("rd_queue_empty", rd_exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
